fwd_hazard_ctrl: RTL and testbench

FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

---
 rtl/fwd_hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use hazard controller for a 5-stage in-order pipeline.
// Tracks EX/MEM/WB producer state and derives operand-mux selects and the stall request.
module fwd_hazard_ctrl #(
    parameter int unsigned REG_AW = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wr,
    input  logic              id_load,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b01;

    // EX stage entry
    logic              r_ex_valid;
    logic [REG_AW-1:0] r_ex_rs1;
    logic [REG_AW-1:0] r_ex_rs2;
    logic              r_ex_use1;
    logic              r_ex_use2;
    logic [REG_AW-1:0] r_ex_rd;
    logic              r_ex_wr;
    logic              r_ex_load;

    // MEM stage entry
    logic              r_mem_valid;
    logic [REG_AW-1:0] r_mem_rd;
    logic              r_mem_wr;
    logic              r_mem_load;

    // WB stage entry
    logic              r_wb_valid;
    logic [REG_AW-1:0] r_wb_rd;
    logic              r_wb_wr;

    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_mem_fwd_ok;
    logic              w_wb_fwd_ok;
    logic              w_hit_rs1;
    logic              w_hit_rs2;
    logic              w_ex_is_load_dst;
    logic              w_stall;
    logic              w_cnt_sat;

    function automatic logic [1:0] fwd_sel(
        input logic              ex_valid,
        input logic              use_src,
        input logic [REG_AW-1:0] src,
        input logic              mem_ok,
        input logic [REG_AW-1:0] mem_rd,
        input logic              wb_ok,
        input logic [REG_AW-1:0] wb_rd
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (ex_valid && use_src && (src != '0)) begin
            // Youngest producer (EX/MEM) wins over the older MEM/WB one.
            if (mem_ok && (mem_rd == src))
                sel = SEL_MEM;
            else if (wb_ok && (wb_rd == src))
                sel = SEL_WB;
        end
        return sel;
    endfunction

    // A load in MEM has no result yet on the EX/MEM path, so it never forwards from there.
    assign w_mem_fwd_ok = r_mem_valid && r_mem_wr && !r_mem_load;
    assign w_wb_fwd_ok  = r_wb_valid && r_wb_wr;

    always_comb begin
        fwd_a_sel = fwd_sel(r_ex_valid, r_ex_use1, r_ex_rs1,
                            w_mem_fwd_ok, r_mem_rd, w_wb_fwd_ok, r_wb_rd);
        fwd_b_sel = fwd_sel(r_ex_valid, r_ex_use2, r_ex_rs2,
                            w_mem_fwd_ok, r_mem_rd, w_wb_fwd_ok, r_wb_rd);
    end

    assign w_ex_is_load_dst = r_ex_valid && r_ex_load && r_ex_wr && (r_ex_rd != '0);
    assign w_hit_rs1        = id_use1 && (id_rs1 == r_ex_rd);
    assign w_hit_rs2        = id_use2 && (id_rs2 == r_ex_rd);
    assign w_stall          = id_valid && w_ex_is_load_dst && (w_hit_rs1 || w_hit_rs2) && !flush;
    assign w_cnt_sat        = (r_stall_cnt == '1);

    assign stall     = w_stall;
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid  <= 1'b0;
            r_ex_rs1    <= '0;
            r_ex_rs2    <= '0;
            r_ex_use1   <= 1'b0;
            r_ex_use2   <= 1'b0;
            r_ex_rd     <= '0;
            r_ex_wr     <= 1'b0;
            r_ex_load   <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_rd    <= '0;
            r_mem_wr    <= 1'b0;
            r_mem_load  <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_wr     <= 1'b0;
            r_stall_cnt <= '0;
        end else if (en) begin
            r_wb_valid  <= r_mem_valid;
            r_wb_rd     <= r_mem_rd;
            r_wb_wr     <= r_mem_wr;

            // A flush also kills the instruction leaving EX this cycle.
            r_mem_valid <= r_ex_valid && !flush;
            r_mem_rd    <= r_ex_rd;
            r_mem_wr    <= r_ex_wr;
            r_mem_load  <= r_ex_load;

            r_ex_valid  <= id_valid && !w_stall && !flush;
            r_ex_rs1    <= id_rs1;
            r_ex_rs2    <= id_rs2;
            r_ex_use1   <= id_use1;
            r_ex_use2   <= id_use2;
            r_ex_rd     <= id_rd;
            r_ex_wr     <= id_wr;
            r_ex_load   <= id_load;

            if (w_stall && !w_cnt_sat)
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed checks of forwarding selects, load-use stall, flush, freeze, saturation and reset.
module tb_fwd_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic        flush;
    logic        id_valid;
    logic [3:0]  id_rs1;
    logic [3:0]  id_rs2;
    logic        id_use1;
    logic        id_use2;
    logic [3:0]  id_rd;
    logic        id_wr;
    logic        id_load;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic        stall;
    logic [15:0] stall_cnt;
    logic [1:0]  sat_a_sel;
    logic [1:0]  sat_b_sel;
    logic        sat_stall;
    logic [3:0]  sat_cnt;

    int unsigned n_vec;
    int unsigned n_err;

    fwd_hazard_ctrl #(.REG_AW(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use1(id_use1), .id_use2(id_use2), .id_rd(id_rd),
        .id_wr(id_wr), .id_load(id_load),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall(stall), .stall_cnt(stall_cnt)
    );

    // Narrow counter copy so saturation is reachable in a short run.
    fwd_hazard_ctrl #(.REG_AW(4), .CNT_W(4)) u_dut_sat (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use1(id_use1), .id_use2(id_use2), .id_rd(id_rd),
        .id_wr(id_wr), .id_load(id_load),
        .fwd_a_sel(sat_a_sel), .fwd_b_sel(sat_b_sel),
        .stall(sat_stall), .stall_cnt(sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [3:0] rs1, input logic u1,
                          input logic [3:0] rs2, input logic u2,
                          input logic [3:0] rd, input logic w, input logic ld);
        id_valid = v;  id_rs1 = rs1; id_use1 = u1; id_rs2 = rs2; id_use2 = u2;
        id_rd    = rd; id_wr  = w;   id_load = ld;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; en = 1'b1; flush = 1'b0;
        set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        #3;
        check_val("rst_a",     {30'd0, fwd_a_sel}, 32'd0);
        check_val("rst_b",     {30'd0, fwd_b_sel}, 32'd0);
        check_val("rst_stall", {31'd0, stall},     32'd0);
        check_val("rst_cnt",   {16'd0, stall_cnt}, 32'd0);
        #3 rst = 1'b0;

        // ADD r3 ; ADD r5,r3,r3
        set_id(1, 4'd1, 1, 4'd2, 1, 4'd3, 1, 0);
        step();
        set_id(1, 4'd3, 1, 4'd3, 1, 4'd5, 1, 0);
        check_val("b2b_stall", {31'd0, stall}, 32'd0);
        step();
        check_val("b2b_a", {30'd0, fwd_a_sel}, 32'h2);
        check_val("b2b_b", {30'd0, fwd_b_sel}, 32'h2);

        // ADD r3 ; unrelated ; SUB r4,r3,r1
        set_id(1, 4'd1, 1, 4'd2, 1, 4'd3, 1, 0);
        step();
        set_id(1, 4'd8, 1, 4'd9, 1, 4'd10, 1, 0);
        step();
        set_id(1, 4'd3, 1, 4'd1, 1, 4'd4, 1, 0);
        step();
        check_val("wb_a", {30'd0, fwd_a_sel}, 32'h1);
        check_val("wb_b", {30'd0, fwd_b_sel}, 32'h0);

        // ADD r3 ; ADD r3 ; SUB r4,r3,r1 -> MEM producer wins
        set_id(1, 4'd1, 1, 4'd2, 1, 4'd3, 1, 0);
        step();
        step();
        set_id(1, 4'd3, 1, 4'd1, 1, 4'd4, 1, 0);
        step();
        check_val("prio_a", {30'd0, fwd_a_sel}, 32'h2);
        check_val("prio_b", {30'd0, fwd_b_sel}, 32'h0);

        // LOAD r2 ; ADD r6,r2,r7
        set_id(1, 4'd1, 1, 4'd0, 0, 4'd2, 1, 1);
        step();
        set_id(1, 4'd2, 1, 4'd7, 1, 4'd6, 1, 0);
        check_val("lu_stall", {31'd0, stall},     32'd1);
        check_val("lu_cnt0",  {16'd0, stall_cnt}, 32'd0);
        step();
        check_val("lu_bub_stall", {31'd0, stall},     32'd0);
        check_val("lu_bub_a",     {30'd0, fwd_a_sel}, 32'h0);
        check_val("lu_cnt1",      {16'd0, stall_cnt}, 32'd1);
        step();
        check_val("lu_res_a",     {30'd0, fwd_a_sel}, 32'h1);
        check_val("lu_res_b",     {30'd0, fwd_b_sel}, 32'h0);
        check_val("lu_res_stall", {31'd0, stall},     32'd0);

        // r0 writer then r0 reader, plain and load
        set_id(1, 4'd1, 1, 4'd2, 1, 4'd0, 1, 0);
        step();
        set_id(1, 4'd0, 1, 4'd0, 1, 4'd0, 0, 0);
        step();
        check_val("r0_a", {30'd0, fwd_a_sel}, 32'h0);
        check_val("r0_b", {30'd0, fwd_b_sel}, 32'h0);
        set_id(1, 4'd1, 1, 4'd0, 0, 4'd0, 1, 1);
        step();
        set_id(1, 4'd0, 1, 4'd0, 1, 4'd0, 0, 0);
        check_val("r0_ld_stall", {31'd0, stall}, 32'd0);
        step();
        check_val("r0_ld_a", {30'd0, fwd_a_sel}, 32'h0);

        // Invalid writer of r3 never forwards
        set_id(0, 4'd1, 1, 4'd2, 1, 4'd3, 1, 0);
        step();
        set_id(1, 4'd3, 1, 4'd3, 1, 4'd0, 0, 0);
        step();
        check_val("inv_a", {30'd0, fwd_a_sel}, 32'h0);
        check_val("inv_b", {30'd0, fwd_b_sel}, 32'h0);

        // Load-use with flush in the same cycle
        set_id(1, 4'd1, 1, 4'd0, 0, 4'd2, 1, 1);
        step();
        set_id(1, 4'd2, 1, 4'd0, 0, 4'd6, 1, 0);
        flush = 1'b1;
        #1;
        check_val("fl_stall", {31'd0, stall}, 32'd0);
        step();
        flush = 1'b0;
        #1;
        check_val("fl_cnt",   {16'd0, stall_cnt}, 32'd1);
        check_val("fl_bub_a", {30'd0, fwd_a_sel}, 32'h0);
        step();
        check_val("fl_killed_ld_a", {30'd0, fwd_a_sel}, 32'h0);

        // en=0 freezes a stall
        set_id(1, 4'd1, 1, 4'd0, 0, 4'd2, 1, 1);
        step();
        set_id(1, 4'd0, 0, 4'd2, 1, 4'd6, 1, 0);
        check_val("frz_stall0", {31'd0, stall}, 32'd1);
        en = 1'b0;
        step();
        step();
        check_val("frz_stall", {31'd0, stall},     32'd1);
        check_val("frz_cnt",   {16'd0, stall_cnt}, 32'd1);
        en = 1'b1;
        step();
        check_val("frz_rel_cnt",   {16'd0, stall_cnt}, 32'd2);
        check_val("frz_rel_stall", {31'd0, stall},     32'd0);

        // 20 more stalls: wide counter reaches 22, 4-bit copy sticks at F
        for (int i = 0; i < 20; i++) begin
            set_id(1, 4'd0, 0, 4'd0, 0, 4'd2, 1, 1);
            step();
            set_id(1, 4'd2, 1, 4'd0, 0, 4'd6, 1, 0);
            step();
        end
        check_val("sat_wide", {16'd0, stall_cnt}, 32'd22);
        check_val("sat_cnt",  {28'd0, sat_cnt},   32'hF);

        // Async reset mid-stall with a live forward
        set_id(1, 4'd1, 1, 4'd2, 1, 4'd3, 1, 0);
        step();
        set_id(1, 4'd3, 1, 4'd0, 0, 4'd2, 1, 1);
        step();
        set_id(1, 4'd2, 1, 4'd3, 1, 4'd6, 1, 0);
        check_val("pre_rst_stall", {31'd0, stall},     32'd1);
        check_val("pre_rst_a",     {30'd0, fwd_a_sel}, 32'h2);
        rst = 1'b1;
        #1;
        check_val("mid_rst_stall", {31'd0, stall},     32'd0);
        check_val("mid_rst_a",     {30'd0, fwd_a_sel}, 32'h0);
        check_val("mid_rst_cnt",   {16'd0, stall_cnt}, 32'd0);
        check_val("mid_rst_sat",   {28'd0, sat_cnt},   32'd0);
        rst = 1'b0;
        set_id(1, 4'd0, 0, 4'd0, 0, 4'd9, 1, 1);
        step();
        set_id(1, 4'd9, 1, 4'd0, 0, 4'd6, 1, 0);
        check_val("post_rst_stall", {31'd0, stall}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
